// File: rtl/ps2_host_tx_if.sv
// Command handshake and PS/2 pad signals shared by the host transmitter and its user.
interface ps2_host_tx_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       busy;
  logic       done;
  logic [1:0] status;

  modport master (
    output cmd_valid, cmd_data, ps2_clk_in, ps2_dat_in,
    input  cmd_ready, ps2_clk_oe, ps2_dat_oe, busy, done, status
  );

  modport slave (
    input  cmd_valid, cmd_data, ps2_clk_in, ps2_dat_in,
    output cmd_ready, ps2_clk_oe, ps2_dat_oe, busy, done, status
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame on
// device clock edges, ACK check, bounded by a saturating timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  ps2_host_tx_if.slave bus
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [IW-1:0] INH_DAT = IW'(INHIBIT_CYCLES - 2);
  localparam logic [IW-1:0] INH_END = IW'(INHIBIT_CYCLES - 1);
  localparam logic [19:0]   TMO_END = 20'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_RELEASE, S_DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] inh_cnt;
  logic [19:0]   tmo_cnt;
  logic [3:0]    bit_idx;
  logic          clk_oe_q;
  logic          dat_oe_q;
  logic          done_q;
  logic [1:0]    status_q;
  logic [7:0]    cmd_byte;
  logic          par_bit;

  logic ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
  logic ps2_dat_p0, ps2_dat_p1;
  logic clk_fall;

  // Line value for frame bit k: data LSB first, then parity, then stop.
  function automatic logic frame_bit(input logic [7:0] d, input logic p, input logic [3:0] k);
    if (k >= 4'd1 && k <= 4'd8) return d[3'(k - 4'd1)];
    else if (k == 4'd9)         return p;
    else                        return 1'b1;
  endfunction

  // Stage p0/p1: two-flop synchronisers; p2 holds the previous clock sample.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      ps2_clk_p0 <= 1'b1;
      ps2_clk_p1 <= 1'b1;
      ps2_clk_p2 <= 1'b1;
      ps2_dat_p0 <= 1'b1;
      ps2_dat_p1 <= 1'b1;
    end else begin
      ps2_clk_p0 <= bus.ps2_clk_in;
      ps2_clk_p1 <= ps2_clk_p0;
      ps2_clk_p2 <= ps2_clk_p1;
      ps2_dat_p0 <= bus.ps2_dat_in;
      ps2_dat_p1 <= ps2_dat_p0;
    end
  end

  assign clk_fall = ps2_clk_p2 & ~ps2_clk_p1;

  always_ff @(posedge CLOCK_50) begin
    if (bus.cmd_valid && state == S_IDLE) begin
      cmd_byte <= bus.cmd_data;
      par_bit  <= ~^bus.cmd_data;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      inh_cnt  <= '0;
      tmo_cnt  <= '0;
      bit_idx  <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      status_q <= 2'b00;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            clk_oe_q <= 1'b1;
            inh_cnt  <= '0;
            state    <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          inh_cnt <= inh_cnt + IW'(1);
          if (inh_cnt == INH_DAT) dat_oe_q <= 1'b1;
          if (inh_cnt == INH_END) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b1;
            bit_idx  <= '0;
            tmo_cnt  <= '0;
            state    <= S_RTS;
          end
        end
        S_RTS, S_SHIFT, S_ACK, S_RELEASE: begin
          if (tmo_cnt >= TMO_END) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            status_q <= 2'b10;
            done_q   <= 1'b1;
            state    <= S_DONE;
          end else begin
            if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 20'd1;
            case (state)
              S_RTS, S_SHIFT: begin
                if (clk_fall) begin
                  bit_idx  <= bit_idx + 4'd1;
                  dat_oe_q <= ~frame_bit(cmd_byte, par_bit, bit_idx + 4'd1);
                  state    <= (bit_idx == 4'd9) ? S_ACK : S_SHIFT;
                end
              end
              S_ACK: begin
                if (clk_fall) begin
                  status_q <= ps2_dat_p1 ? 2'b01 : 2'b00;
                  state    <= S_RELEASE;
                end
              end
              S_RELEASE: begin
                if (ps2_clk_p1 && ps2_dat_p1) begin
                  done_q <= 1'b1;
                  state  <= S_DONE;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
        // One cycle with done high, still busy, before accepting again.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = (state == S_IDLE);
  assign bus.busy       = (state != S_IDLE);
  assign bus.ps2_clk_oe = clk_oe_q;
  assign bus.ps2_dat_oe = dat_oe_q;
  assign bus.done       = done_q;
  assign bus.status     = status_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain pad model and a PS/2 device model.
module tb_ps2_host_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int acc_cyc = 0;
  int fall_cyc = 0;
  int clk_oe_cnt = 0;
  logic [1:0] last_status = 2'b00;
  logic [1:0] done_oe = 2'b00;
  logic [7:0] acc_data = 8'h00;
  logic clk_oe_prev = 1'b0;

  ps2_host_tx_if bus ();

  ps2_host_tx #(.INHIBIT_CYCLES(10), .TIMEOUT_CYCLES(5000)) dut (
    .CLOCK_50(clk),
    .reset   (rst),
    .bus     (bus)
  );

  assign bus.ps2_clk_in = ~bus.ps2_clk_oe & dev_clk;
  assign bus.ps2_dat_in = ~bus.ps2_dat_oe & dev_dat;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.done === 1'b1) begin
      done_cnt    = done_cnt + 1;
      done_cyc    = cyc;
      last_status = bus.status;
      done_oe     = {bus.ps2_clk_oe, bus.ps2_dat_oe};
    end
    if (bus.cmd_valid && bus.cmd_ready) begin
      acc_cyc  = cyc;
      acc_data = bus.cmd_data;
    end
    if (bus.ps2_clk_oe === 1'b1) clk_oe_cnt = clk_oe_cnt + 1;
    if (clk_oe_prev && bus.ps2_clk_oe === 1'b0) fall_cyc = cyc;
    clk_oe_prev = bus.ps2_clk_oe;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b, input bit hold);
    for (int i = 0; i < 50; i++) begin
      if (bus.cmd_ready === 1'b1) break;
      tick(1);
    end
    bus.cmd_data  = b;
    bus.cmd_valid = 1'b1;
    tick(1);
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, input int d0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  // Device clocks at 80-cycle period once it sees data low with clock released.
  task automatic device_frame(input bit nack, input int stop_edge,
                              output logic [10:0] bits, output bit ok);
    ok   = 1'b0;
    bits = 'x;
    for (int i = 0; i < 200; i++) begin
      if (bus.ps2_clk_in === 1'b1 && bus.ps2_dat_in === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    if (!ok) return;
    bits[0] = bus.ps2_dat_in;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) begin
        tick(20);
        dev_dat = nack;
        tick(20);
      end else begin
        tick(40);
      end
      dev_clk = 1'b0;
      if (k == stop_edge) begin
        tick(10);
        return;
      end
      tick(40);
      dev_clk = 1'b1;
      if (k <= 10) bits[k] = bus.ps2_dat_in;
    end
    tick(5);
    dev_dat = 1'b1;
  endtask

  task automatic test_reset;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    rst = 1'b1;
    tick(3);
    checks++; if (bus.ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe: got %b want 0", bus.ps2_clk_oe); end
    checks++; if (bus.ps2_dat_oe !== 1'b0) begin errors++; $display("FAIL reset_dat_oe: got %b want 0", bus.ps2_dat_oe); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.status !== 2'b00) begin errors++; $display("FAIL reset_status: got %b want 00", bus.status); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_ack;
    logic [10:0] bits;
    bit ok, ok2;
    int d0 = done_cnt;
    int c0 = clk_oe_cnt;
    send_cmd(8'hED, 1'b0);
    device_frame(1'b0, 0, bits, ok);
    wait_done(100, d0, ok2);
    tick(3);
    checks++; if (!ok || !ok2) begin errors++; $display("FAIL ack_progress: rts=%0b done=%0b want 1 1", ok, ok2); end
    checks++; if (clk_oe_cnt - c0 != 10) begin errors++; $display("FAIL ack_inhibit_len: got %0d want 10", clk_oe_cnt - c0); end
    checks++; if (bits !== 11'b1_1_11101101_0) begin errors++; $display("FAIL ack_bits: got %b want %b", bits, 11'b1_1_11101101_0); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ack_done_pulse: got %0d cycles want 1", done_cnt - d0); end
    checks++; if (last_status !== 2'b00) begin errors++; $display("FAIL ack_status: got %b want 00", last_status); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL ack_ready: got %b want 1", bus.cmd_ready); end
  endtask

  task automatic test_nack;
    logic [10:0] bits;
    bit ok, ok2;
    int d0 = done_cnt;
    send_cmd(8'hF4, 1'b0);
    device_frame(1'b1, 0, bits, ok);
    wait_done(100, d0, ok2);
    tick(3);
    checks++; if (!ok || !ok2) begin errors++; $display("FAIL nack_progress: rts=%0b done=%0b want 1 1", ok, ok2); end
    checks++; if (bits !== 11'b1_0_11110100_0) begin errors++; $display("FAIL nack_bits: got %b want %b", bits, 11'b1_0_11110100_0); end
    checks++; if (last_status !== 2'b01) begin errors++; $display("FAIL nack_status: got %b want 01", last_status); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL nack_done_pulse: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_timeout;
    bit ok;
    int d0 = done_cnt;
    send_cmd(8'hFF, 1'b0);
    tick(100);
    checks++; if ({bus.ps2_clk_oe, bus.ps2_dat_oe} !== 2'b01) begin errors++; $display("FAIL tmo_rts_lines: got %b want 01", {bus.ps2_clk_oe, bus.ps2_dat_oe}); end
    wait_done(6000, d0, ok);
    tick(2);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_done_seen: got 0 want 1"); end
    checks++; if (done_cyc - fall_cyc != 5000) begin errors++; $display("FAIL tmo_cycles: got %0d want 5000", done_cyc - fall_cyc); end
    checks++; if (done_oe !== 2'b00) begin errors++; $display("FAIL tmo_lines: got %b want 00", done_oe); end
    checks++; if (last_status !== 2'b10) begin errors++; $display("FAIL tmo_status: got %b want 10", last_status); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL tmo_idle: busy got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid;
    logic [10:0] bits;
    bit ok, ok2;
    int d0;
    send_cmd(8'h00, 1'b0);
    device_frame(1'b0, 5, bits, ok);
    checks++; if (!ok || bus.ps2_dat_oe !== 1'b1) begin errors++; $display("FAIL mid_pre_reset: rts=%0b dat_oe=%b want 1 1", ok, bus.ps2_dat_oe); end
    rst = 1'b1;
    #1;
    checks++; if ({bus.ps2_clk_oe, bus.ps2_dat_oe} !== 2'b00) begin errors++; $display("FAIL mid_reset_lines: got %b want 00", {bus.ps2_clk_oe, bus.ps2_dat_oe}); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b want 0", bus.busy); end
    dev_clk = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
    d0 = done_cnt;
    send_cmd(8'hF4, 1'b0);
    device_frame(1'b0, 0, bits, ok);
    wait_done(100, d0, ok2);
    tick(3);
    checks++; if (bits !== 11'b1_0_11110100_0) begin errors++; $display("FAIL mid_after_bits: got %b want %b", bits, 11'b1_0_11110100_0); end
    checks++; if (!ok2 || last_status !== 2'b00) begin errors++; $display("FAIL mid_after_status: done=%0b status=%b want 1 00", ok2, last_status); end
  endtask

  task automatic test_hold_valid;
    logic [10:0] bits;
    bit ok, ok2;
    int d0 = done_cnt;
    send_cmd(8'hED, 1'b1);
    bus.cmd_data = 8'hAA;
    device_frame(1'b0, 0, bits, ok);
    wait_done(100, d0, ok2);
    tick(1);
    bus.cmd_valid = 1'b0;
    checks++; if (bits !== 11'b1_1_11101101_0) begin errors++; $display("FAIL hold_first_bits: got %b want %b", bits, 11'b1_1_11101101_0); end
    checks++; if (!ok2 || last_status !== 2'b00) begin errors++; $display("FAIL hold_first_status: done=%0b status=%b want 1 00", ok2, last_status); end
    checks++; if (acc_cyc != done_cyc + 1) begin errors++; $display("FAIL hold_accept_cycle: got %0d want %0d", acc_cyc, done_cyc + 1); end
    checks++; if (acc_data !== 8'hAA) begin errors++; $display("FAIL hold_accept_data: got %h want aa", acc_data); end
    d0 = done_cnt;
    device_frame(1'b0, 0, bits, ok);
    wait_done(100, d0, ok2);
    tick(3);
    checks++; if (bits !== 11'b1_1_10101010_0) begin errors++; $display("FAIL hold_second_bits: got %b want %b", bits, 11'b1_1_10101010_0); end
    checks++; if (!ok2 || last_status !== 2'b00) begin errors++; $display("FAIL hold_second_status: done=%0b status=%b want 1 00", ok2, last_status); end
  endtask

  task automatic test_back_to_back;
    logic [10:0] bits_a, bits_b;
    logic [1:0] st_a;
    bit ok, ok2;
    int d0 = done_cnt;
    send_cmd(8'hED, 1'b0);
    device_frame(1'b0, 0, bits_a, ok);
    wait_done(100, d0, ok2);
    st_a = last_status;
    send_cmd(8'h02, 1'b0);
    device_frame(1'b0, 0, bits_b, ok);
    wait_done(100, d0 + 1, ok2);
    tick(3);
    checks++; if (bits_a !== 11'b1_1_11101101_0) begin errors++; $display("FAIL b2b_first_bits: got %b want %b", bits_a, 11'b1_1_11101101_0); end
    checks++; if (st_a !== 2'b00) begin errors++; $display("FAIL b2b_first_status: got %b want 00", st_a); end
    checks++; if (bits_b !== 11'b1_0_00000010_0) begin errors++; $display("FAIL b2b_second_bits: got %b want %b", bits_b, 11'b1_0_00000010_0); end
    checks++; if (last_status !== 2'b00) begin errors++; $display("FAIL b2b_second_status: got %b want 00", last_status); end
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    test_reset();
    test_ack();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_hold_valid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
